// File: rtl/mul_writeback_unit_pkg.sv
// Shared constants and state encoding for the shift-add multiplier
// and its register-file writeback sequencer.
package mul_writeback_unit_pkg;
    localparam int WIDTH      = 24;
    localparam int REG_ADDR_W = 4;
    localparam int CNT_W      = $clog2(WIDTH);

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 4'b0000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MUL   = 2'd1;
    localparam logic [1:0] ST_WR_LO = 2'd2;
    localparam logic [1:0] ST_WR_HI = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_MUL   = ST_MUL,
        S_WR_LO = ST_WR_LO,
        S_WR_HI = ST_WR_HI
    } state_t;
endpackage

// File: rtl/mul_writeback_unit_if.sv
// Request side (Start/operands/destinations/WbStall) and register-file write side
// of the multiplier. master = the multiply unit, slave = whoever drives it.
interface mul_writeback_unit_if;
    import mul_writeback_unit_pkg::*;

    // Handshake: a request is accepted on a rising edge where Start=1 and Busy=0.
    // The write port is only driven while WbStall=0; a stalled write holds RD/WriteData.
    logic                    Start;
    logic [WIDTH-1:0]        OpA;
    logic [WIDTH-1:0]        OpB;
    logic [REG_ADDR_W-1:0]   DestLo;
    logic [REG_ADDR_W-1:0]   DestHi;
    logic                    WbStall;
    logic [REG_ADDR_W-1:0]   RD;
    logic [WIDTH-1:0]        WriteData;
    logic                    RegWrite;
    logic                    Busy;
    logic                    Done;
    logic [2*WIDTH-1:0]      MulResult;

    modport master (
        input  Start, OpA, OpB, DestLo, DestHi, WbStall,
        output RD, WriteData, RegWrite, Busy, Done, MulResult
    );

    modport slave (
        output Start, OpA, OpB, DestLo, DestHi, WbStall,
        input  RD, WriteData, RegWrite, Busy, Done, MulResult
    );
endinterface

// File: rtl/mul_writeback_unit_shift_add_datapath.sv
// Shift-add accumulator: one multiplier bit per step, counter-indexed,
// with a flag marking the final step.
module shift_add_datapath
    import mul_writeback_unit_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_op_a,
    input  logic [WIDTH-1:0]   i_op_b,
    output logic [2*WIDTH-1:0] o_acc,
    output logic               o_last
);
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] w_addend;

    // Partial products never exceed 2*WIDTH bits, so the sum cannot overflow.
    assign w_addend = r_mplier[r_cnt] ? (r_mcand << r_cnt) : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_op_a};
            r_mplier <= i_op_b;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (i_step) begin
            r_acc <= r_acc + w_addend;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_acc  = r_acc;
    assign o_last = (r_cnt == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/mul_writeback_unit.sv
// 24x24 multi-cycle multiplier that writes its 48-bit product back to the
// register file as two half-word writes (low, then high), yielding to WbStall.
module mul_writeback_unit
    import mul_writeback_unit_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    mul_writeback_unit_if.master  bus,
    output state_t                o_state
);
    state_t                r_state;
    logic [REG_ADDR_W-1:0] r_dest_lo;
    logic [REG_ADDR_W-1:0] r_dest_hi;
    logic [2*WIDTH-1:0]    r_mul_result;
    logic [2*WIDTH-1:0]    w_acc;
    logic                  w_last;
    logic                  w_load;
    logic                  w_step;

    assign w_load = (r_state == S_IDLE) && bus.Start;
    assign w_step = (r_state == S_MUL);

    shift_add_datapath u_datapath (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_load),
        .i_step (w_step),
        .i_op_a (bus.OpA),
        .i_op_b (bus.OpB),
        .o_acc  (w_acc),
        .o_last (w_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_dest_lo    <= REG_ZERO;
            r_dest_hi    <= REG_ZERO;
            r_mul_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        r_dest_lo <= bus.DestLo;
                        r_dest_hi <= bus.DestHi;
                        r_state   <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (w_last) r_state <= S_WR_LO;
                end
                S_WR_LO: begin
                    if (!bus.WbStall) r_state <= S_WR_HI;
                end
                S_WR_HI: begin
                    if (!bus.WbStall) begin
                        r_mul_result <= w_acc;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Register 0 is hardwired zero: its write slot is still spent, just without an enable.
    always_comb begin
        bus.RD        = REG_ZERO;
        bus.WriteData = '0;
        bus.RegWrite  = 1'b0;
        bus.Done      = 1'b0;
        case (r_state)
            S_WR_LO: begin
                bus.RD        = r_dest_lo;
                bus.WriteData = w_acc[WIDTH-1:0];
                bus.RegWrite  = !bus.WbStall && (r_dest_lo != REG_ZERO);
            end
            S_WR_HI: begin
                bus.RD        = r_dest_hi;
                bus.WriteData = w_acc[2*WIDTH-1:WIDTH];
                bus.RegWrite  = !bus.WbStall && (r_dest_hi != REG_ZERO);
                bus.Done      = !bus.WbStall;
            end
            default: ;
        endcase
    end

    assign bus.Busy      = (r_state != S_IDLE);
    assign bus.MulResult = r_mul_result;
    assign o_state       = r_state;
endmodule

// File: doc/mul_writeback_unit.md
Name: mul_writeback_unit

Overview:
- Multi-cycle 24x24 unsigned shift-add multiplier that drives the register-file write port (RD / WriteData / RegWrite), i.e. the writer side of that interface.
- Produces a 48-bit product, holds it in an internal MULREG-equivalent register, then writes it back as two 24-bit register writes: low half, then high half.
- Sits beside the ALU in the execute/writeback path and shares the write port with the main writeback mux through a stall handshake.

Parameters:
- WIDTH, 24, operand width; product is 2*WIDTH.
- REG_ADDR_W, 4, register address width (16 registers).

Ports:
- Clock  input  1  single system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request a multiply; sampled only in IDLE.
- OpA  input  WIDTH  multiplicand, captured when Start is accepted.
- OpB  input  WIDTH  multiplier, captured when Start is accepted.
- DestLo  input  REG_ADDR_W  destination of product[WIDTH-1:0], captured with Start.
- DestHi  input  REG_ADDR_W  destination of product[2*WIDTH-1:WIDTH], captured with Start.
- WbStall  input  1  write port owned by main writeback this cycle.
- RD  output  REG_ADDR_W  write address to register file.
- WriteData  output  WIDTH  write data to register file.
- RegWrite  output  1  write enable to register file.
- Busy  output  1  unit occupied; new Start ignored.
- Done  output  1  one-cycle pulse on the final (high-half) write.
- MulResult  output  2*WIDTH  last completed product (MULREG).

Behaviour:
- Clock and reset: one clock (Clock); reset is synchronous and active-high (Reset).
- Reset values: state IDLE, counter 0, RD 0, WriteData 0, RegWrite 0, Busy 0, Done 0, MulResult 0.
- Reset mid-operation aborts the multiply. No further RegWrite is asserted, and any partial product is discarded.
- States: IDLE, MUL, WR_LO, WR_HI.
- IDLE:
  - Busy=0.
  - Start=1 at edge T latches OpA, OpB, DestLo and DestHi, clears the accumulator and counter, and moves to MUL.
- MUL:
  - Busy=1.
  - Each edge examines multiplier bit[counter]. If set, add OpA<<counter into the 2*WIDTH accumulator; the addition is unsigned with no overflow possible.
  - counter increments each edge. After WIDTH edges (edge T+WIDTH) go to WR_LO.
- WR_LO:
  - Busy=1; RD=DestLo; WriteData=acc[WIDTH-1:0].
  - RegWrite = !WbStall && (DestLo != 0).
  - Advance to WR_HI on an edge where WbStall=0; otherwise hold.
- WR_HI:
  - Busy=1; Done=1 only when WbStall=0; RD=DestHi; WriteData=acc[2*WIDTH-1:WIDTH].
  - RegWrite = !WbStall && (DestHi != 0).
  - On an edge with WbStall=0: MulResult <= acc, then go to IDLE.
- Unstalled latency: the register file captures the low half at edge T+WIDTH+1 and the high half at edge T+WIDTH+2. Busy deasserts in the cycle after edge T+WIDTH+2.
- Decode: RD, WriteData, RegWrite and Done are combinational decodes of the state and registered data. RegWrite is never high outside WR_LO and WR_HI.
- Register 0 is the zero register:
  - A write targeting 0 still consumes its cycle but never asserts RegWrite.
  - DestLo == DestHi != 0: both writes occur, and the high half wins.
- Start while Busy=1 is ignored; operands and destinations stay frozen.
- Start in the same cycle that WR_HI completes is ignored. It must be re-presented while Busy=0.
- WbStall outside the WR states has no effect; MUL progress is never stalled.
- Operand 0 runs the full WIDTH cycles and writes 0s. There is no early exit.

Decomposition:
- Shared cpu package holds:
  - WIDTH=24 and REG_ADDR_W=4 constants.
  - REG_ZERO=4'b0000.
  - The state encoding localparams (IDLE=0, MUL=1, WR_LO=2, WR_HI=3).
- Sub-module: shift_add_datapath. It contains the accumulator, shifted-multiplicand add and counter, with load/step inputs and a last-step flag. The FSM and write-port drive stay in the top module.

Test Plan:
- Basic multiply: OpA=3, OpB=5, DestLo=2, DestHi=3, Start at edge T, WbStall=0.
  - RegWrite with RD=2, WriteData=0x00000F captured at T+25.
  - RD=3, WriteData=0x000000 captured at T+26, with Done high that cycle.
  - MulResult=0x00000000000F.
- Max operands: OpA=OpB=0xFFFFFF.
  - Low write 0x000001, high write 0xFFFFFE.
  - MulResult=0xFFFFFE000001.
- Stall: same as the basic multiply, with WbStall=1 for 3 cycles upon entering WR_LO.
  - RegWrite stays 0 and RD/WriteData hold.
  - Writes then land at T+28 and T+29; Done pulses exactly once.
- Zero destination: DestLo=0, DestHi=7, OpA=0x000100, OpB=0x010000.
  - No RegWrite in WR_LO.
  - r7 <= 0x000001 in WR_HI.
- Busy lockout: second Start with different operands at T+5.
  - Ignored; the result matches the first operands only.
  - Busy=0 after T+26.
- Reset mid-op: Reset=1 at T+10 for one cycle.
  - Next cycle: Busy=0, RegWrite=0, MulResult=0.
  - No writes occur through T+30.
